// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR writeback path.
// Purely declarative: no logic, no latency, no flow control.
package gpr_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        WB_SRC_EX  = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/gpr_wb_grant.sv
// EX/MEM writeback grant policy, combinational (0 cycles), no backpressure of its own.
// GPR_WB_ARB_RR_EN selects round-robin; otherwise MEM priority with an EX starvation guard.
module gpr_wb_grant
    import gpr_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_ex_valid,
    input  logic       i_mem_valid,
    input  logic [3:0] i_starve_cnt,
    input  wb_src_e    i_last_grant,
    output logic [1:0] o_grant
);

    logic w_unused;

    // o_grant[0] = EX, o_grant[1] = MEM; at most one bit set.
    always_comb begin
        o_grant = 2'b00;
        if (i_ex_valid && i_mem_valid) begin
`ifdef GPR_WB_ARB_RR_EN
            o_grant = (i_last_grant == WB_SRC_MEM) ? 2'b01 : 2'b10;
`else
            o_grant = (i_starve_cnt == 4'(STARVE_LIMIT)) ? 2'b01 : 2'b10;
`endif
        end else if (i_ex_valid) begin
            o_grant = 2'b01;
        end else if (i_mem_valid) begin
            o_grant = 2'b10;
        end
    end

`ifdef GPR_WB_ARB_RR_EN
    assign w_unused = ^i_starve_cnt;
`else
    assign w_unused = ^i_last_grant;
`endif

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between EX and MEM writeback; winner is registered, GPR sees it 1 cycle later.
// Ready is combinational from the valids; the output register always drains (no backpressure). Policy macro: GPR_WB_ARB_RR_EN.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH   = XLEN,
    parameter int RF_SIZE      = REG_IDX_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic [RF_SIZE-1:0]    ex_rd_i,
    input  logic [DATA_WIDTH-1:0] ex_data_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [RF_SIZE-1:0]    mem_rd_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  write_enable_o,
    output logic [RF_SIZE-1:0]    rd_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  src_o,
    output logic [3:0]            starve_cnt_o
);

    logic [1:0]            w_grant;
    logic                  w_ex_acc;
    logic                  w_mem_acc;
    logic [RF_SIZE-1:0]    w_win_rd;
    logic [DATA_WIDTH-1:0] w_win_data;

    logic [3:0]            r_starve_cnt;
    wb_src_e               r_last_grant;
    logic                  r_we;
    logic [RF_SIZE-1:0]    r_rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_src;

    gpr_wb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .i_ex_valid   (ex_valid_i),
        .i_mem_valid  (mem_valid_i),
        .i_starve_cnt (r_starve_cnt),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Nothing is accepted while reset is held, so sources simply re-present afterwards.
    assign ex_ready_o  = w_grant[0] & ~rst;
    assign mem_ready_o = w_grant[1] & ~rst;
    assign w_ex_acc    = ex_valid_i  & ex_ready_o;
    assign w_mem_acc   = mem_valid_i & mem_ready_o;

    assign w_win_rd   = w_mem_acc ? mem_rd_i   : ex_rd_i;
    assign w_win_data = w_mem_acc ? mem_data_i : ex_data_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_last_grant <= WB_SRC_MEM;
        end else begin
`ifdef GPR_WB_ARB_RR_EN
            r_starve_cnt <= '0;
`else
            if (!ex_valid_i || w_ex_acc) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != 4'(STARVE_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
`endif
            if (w_mem_acc) begin
                r_last_grant <= WB_SRC_MEM;
            end else if (w_ex_acc) begin
                r_last_grant <= WB_SRC_EX;
            end
        end
    end

    // x0 writes are consumed like any other but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
            r_src  <= 1'b0;
        end else if (w_ex_acc || w_mem_acc) begin
            r_we   <= (w_win_rd != '0);
            r_rd   <= w_win_rd;
            r_data <= w_win_data;
            r_src  <= w_mem_acc;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign write_enable_o = r_we;
    assign rd_o           = r_rd;
    assign data_o         = r_data;
    assign src_o          = r_src;
    assign starve_cnt_o   = r_starve_cnt;

endmodule
